// File: rtl/axi_tdd_ng_pkg.sv
// Shared types and constants for the TDD-NG frame scheduler slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_tdd_ng_pkg;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    STOP = 2'd3
  } sched_state_t;

  // cfg_field selectors; value 3 is reserved and writes to it are dropped
  localparam logic [1:0] FIELD_FRAME_LEN = 2'd0;
  localparam logic [1:0] FIELD_REPEAT    = 2'd1;
  localparam logic [1:0] FIELD_CH_MASK   = 2'd2;

endpackage

// File: rtl/axi_tdd_ng_slot_table.sv
// Profile table: per-slot frame length, repeat count and channel mask.
// Latency: writes visible the cycle after cfg_wr; read port is combinational.
// Backpressure: none, writes are always accepted.
module axi_tdd_ng_slot_table #(
  parameter int  SLOT_COUNT     = 4,
  parameter int  REGISTER_WIDTH = 32,
  parameter int  REPEAT_WIDTH   = 16,
  parameter int  CHANNEL_COUNT  = 8,
  localparam int SLOT_W         = $clog2(SLOT_COUNT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_wr,
  input  logic [SLOT_W-1:0]         cfg_slot,
  input  logic [1:0]                cfg_field,
  input  logic [31:0]               cfg_data,
  input  logic [SLOT_W-1:0]         rd_slot,
  output logic [REGISTER_WIDTH-1:0] rd_frame_len,
  output logic [REPEAT_WIDTH-1:0]   rd_repeat,
  output logic [CHANNEL_COUNT-1:0]  rd_ch_mask
);
  import axi_tdd_ng_pkg::*;

  logic [REGISTER_WIDTH-1:0] r_len  [SLOT_COUNT];
  logic [REPEAT_WIDTH-1:0]   r_rep  [SLOT_COUNT];
  logic [CHANNEL_COUNT-1:0]  r_mask [SLOT_COUNT];

  // Clear the table on reset; otherwise write the selected field, truncating cfg_data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOT_COUNT; i++) begin
        r_len[i]  <= '0;
        r_rep[i]  <= '0;
        r_mask[i] <= '0;
      end
    end else if (cfg_wr) begin
      case (cfg_field)
        FIELD_FRAME_LEN: r_len[cfg_slot]  <= cfg_data[REGISTER_WIDTH-1:0];
        FIELD_REPEAT:    r_rep[cfg_slot]  <= cfg_data[REPEAT_WIDTH-1:0];
        FIELD_CH_MASK:   r_mask[cfg_slot] <= cfg_data[CHANNEL_COUNT-1:0];
        default:         ;
      endcase
    end
  end

  assign rd_frame_len = r_len[rd_slot];
  assign rd_repeat    = r_rep[rd_slot];
  assign rd_ch_mask   = r_mask[rd_slot];

endmodule

// File: rtl/axi_tdd_ng_frame_sched.sv
// Frame scheduler: steps the TDD counter through a sequence of table profiles.
// Latency: tdd_enable 2 cycles after start; new slot outputs 1 cycle after end-of-frame.
// Backpressure: none; stop pre-empts, STOP waits for tdd_active to fall before done.
module axi_tdd_ng_frame_sched #(
  parameter int  SLOT_COUNT     = 4,
  parameter int  REGISTER_WIDTH = 32,
  parameter int  REPEAT_WIDTH   = 16,
  parameter int  CHANNEL_COUNT  = 8,
  localparam int SLOT_W         = $clog2(SLOT_COUNT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_wr,
  input  logic [SLOT_W-1:0]         cfg_slot,
  input  logic [1:0]                cfg_field,
  input  logic [31:0]               cfg_data,
  input  logic [SLOT_W:0]           seq_len,
  input  logic                      loop_en,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      tdd_endof_frame,
  input  logic                      tdd_active,
  output logic                      tdd_enable,
  output logic [REGISTER_WIDTH-1:0] tdd_frame_length,
  output logic [CHANNEL_COUNT-1:0]  tdd_channel_en,
  output logic [SLOT_W-1:0]         cur_slot,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);
  import axi_tdd_ng_pkg::*;

  localparam logic [SLOT_W:0]       LEN_ONE  = (SLOT_W+1)'(1);
  localparam logic [SLOT_W:0]       LEN_MAX  = (SLOT_W+1)'(SLOT_COUNT);
  localparam logic [SLOT_W-1:0]     SLOT_ONE = SLOT_W'(1);
  localparam logic [REPEAT_WIDTH-1:0] REP_ONE = REPEAT_WIDTH'(1);

  sched_state_t              r_state;
  logic [SLOT_W-1:0]         r_slot;
  logic [SLOT_W:0]           r_seq_len;
  logic                      r_loop;
  logic [REPEAT_WIDTH-1:0]   r_rep_cnt;
  logic                      r_enable;
  logic [REGISTER_WIDTH-1:0] r_len;
  logic [CHANNEL_COUNT-1:0]  r_mask;
  logic [SLOT_W-1:0]         r_cur_slot;
  logic                      r_done;
  logic                      r_err;

  logic                      w_seq_ok;
  logic                      w_last;
  logic [SLOT_W-1:0]         w_next_slot;
  logic [SLOT_W-1:0]         w_rd_slot;
  logic [REGISTER_WIDTH-1:0] w_rd_len;
  logic [REPEAT_WIDTH-1:0]   w_rd_rep;
  logic [CHANNEL_COUNT-1:0]  w_rd_mask;

  assign w_seq_ok    = (seq_len != '0) && (seq_len <= LEN_MAX);
  assign w_last      = ({1'b0, r_slot} == (r_seq_len - LEN_ONE));
  assign w_next_slot = w_last ? '0 : (r_slot + SLOT_ONE);
  // In RUN the only table read that matters is the in-place load of the next slot
  assign w_rd_slot   = (r_state == RUN) ? w_next_slot : r_slot;

  axi_tdd_ng_slot_table #(
    .SLOT_COUNT    (SLOT_COUNT),
    .REGISTER_WIDTH(REGISTER_WIDTH),
    .REPEAT_WIDTH  (REPEAT_WIDTH),
    .CHANNEL_COUNT (CHANNEL_COUNT)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .cfg_wr      (cfg_wr),
    .cfg_slot    (cfg_slot),
    .cfg_field   (cfg_field),
    .cfg_data    (cfg_data),
    .rd_slot     (w_rd_slot),
    .rd_frame_len(w_rd_len),
    .rd_repeat   (w_rd_rep),
    .rd_ch_mask  (w_rd_mask)
  );

  // Sequencer FSM with repeat counter; done/err are single-cycle pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_slot     <= '0;
      r_seq_len  <= '0;
      r_loop     <= 1'b0;
      r_rep_cnt  <= '0;
      r_enable   <= 1'b0;
      r_len      <= '0;
      r_mask     <= '0;
      r_cur_slot <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          // stop in the same cycle cancels the start entirely
          if (start && !stop) begin
            if (w_seq_ok) begin
              r_seq_len <= seq_len;
              r_loop    <= loop_en;
              r_slot    <= '0;
              r_state   <= LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          r_len      <= w_rd_len;
          r_mask     <= w_rd_mask;
          r_cur_slot <= r_slot;
          r_rep_cnt  <= w_rd_rep;
          r_enable   <= 1'b1;
          r_state    <= RUN;
        end
        RUN: begin
          if (stop) begin
            r_enable <= 1'b0;
            r_state  <= STOP;
          end else if (tdd_endof_frame) begin
            if (r_rep_cnt != '0) begin
              r_rep_cnt <= r_rep_cnt - REP_ONE;
            end else if (!w_last || r_loop) begin
              r_slot     <= w_next_slot;
              r_cur_slot <= w_next_slot;
              r_len      <= w_rd_len;
              r_mask     <= w_rd_mask;
              r_rep_cnt  <= w_rd_rep;
            end else begin
              r_enable <= 1'b0;
              r_state  <= STOP;
            end
          end
        end
        STOP: begin
          r_enable <= 1'b0;
          if (!tdd_active) begin
            r_state    <= IDLE;
            r_done     <= 1'b1;
            r_cur_slot <= '0;
            r_mask     <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tdd_enable       = r_enable;
  assign tdd_frame_length = r_len;
  assign tdd_channel_en   = r_mask;
  assign cur_slot         = r_cur_slot;
  assign busy             = (r_state != IDLE);
  assign done             = r_done;
  assign err              = r_err;

endmodule
